// File: rtl/mips_muldiv_unit.sv
// -----------------------------------------------------------------------------
// mips_muldiv_unit
//   Iterative multiply/divide unit with HI/LO result registers for the MIPS
//   R-type group mult, multu, div, divu, mthi and mtlo.
//
//   Handshake: an operation is accepted on a rising edge where start=1,
//   busy=0 and funct is one of the supported codes. mthi/mtlo write HI/LO at
//   that edge and never raise busy. mult/div raise busy until the result edge.
//   done pulses for one cycle in the cycle after hi/lo were written. start
//   while busy is dropped, never queued. flush while busy abandons the
//   operation without a done pulse and without touching hi/lo.
//
//   Optional build macro FAST_MUL_EN: when defined, mult/multu form the
//   product in one step at accept and go straight to sign fix-up (done two
//   cycles after accept). Division is iterative in both builds.
//
// Parameters
//   WIDTH  operand and HI/LO width (>= 4)
//   CNT_W  iteration counter width (derived)
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        operation request, sampled only when busy=0
//   funct        R-type funct field
//   rs_val       operand A (multiplicand / dividend / mthi-mtlo source)
//   rt_val       operand B (multiplier / divisor)
//   flush        abort an in-flight operation
//   busy         operation in progress
//   done         one-cycle pulse: hi/lo just updated
//   div_by_zero  one-cycle pulse with done when the divisor was zero
//   hi, lo       HI and LO registers
// -----------------------------------------------------------------------------
module mips_muldiv_unit #(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] rs_val,
   input  logic [WIDTH-1:0] rt_val,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      FIX  = 2'd3
   } state_t;

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   // mult: {partial product high, remaining multiplier bits}
   // div:  {partial remainder, dividend bits shifting into quotient}
   logic [2*WIDTH-1:0] acc, acc_nxt;
   // mult: multiplicand magnitude; div: divisor magnitude
   logic [WIDTH-1:0]   op, op_nxt;
   logic               sa, sa_nxt;
   logic               sb, sb_nxt;
   logic               is_div, is_div_nxt;
   logic               zdiv, zdiv_nxt;
   logic [WIDTH-1:0]   hi_nxt, lo_nxt;
   logic               done_nxt, dbz_nxt;

   // Operand magnitudes; |MIN| = 2^(WIDTH-1) still fits unsigned.
   logic               op_signed;
   logic [WIDTH-1:0]   a_mag, b_mag;
   assign op_signed = (funct == F_MULT) || (funct == F_DIV);
   assign a_mag     = (op_signed && rs_val[WIDTH-1]) ? -rs_val : rs_val;
   assign b_mag     = (op_signed && rt_val[WIDTH-1]) ? -rt_val : rt_val;

`ifdef FAST_MUL_EN
   logic [2*WIDTH-1:0] fast_prod;
   assign fast_prod = {{WIDTH{1'b0}}, a_mag} * {{WIDTH{1'b0}}, b_mag};
`endif

   // Shift-add step: add multiplicand to the high half when the current
   // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
   logic [WIDTH:0] mul_sum;
   assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, op} : '0);

   // Restoring step: shift in the next dividend bit and trial-subtract.
   // The shifted remainder needs WIDTH+1 bits before the compare.
   logic [WIDTH:0] div_trial, div_diff;
   logic           div_ge;
   assign div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
   assign div_ge    = div_trial >= {1'b0, op};
   assign div_diff  = div_trial - {1'b0, op};

   // Sign fix-up. Division by zero needs no special case for hi: with a zero
   // divisor every trial succeeds, the remainder ends as |rs_val| and taking
   // the dividend's sign restores the original rs_val.
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix, rem_fix;
   assign prod_fix = (sa ^ sb) ? -acc : acc;
   assign quo_fix  = (sa ^ sb) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   assign rem_fix  = sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

   always_comb begin
      state_nxt  = state;
      cnt_nxt    = cnt;
      acc_nxt    = acc;
      op_nxt     = op;
      sa_nxt     = sa;
      sb_nxt     = sb;
      is_div_nxt = is_div;
      zdiv_nxt   = zdiv;
      hi_nxt     = hi;
      lo_nxt     = lo;
      done_nxt   = 1'b0;
      dbz_nxt    = 1'b0;
      case (state)
         IDLE: begin
            // flush is meaningless here; start always wins.
            if (start) begin
               case (funct)
                  F_MTHI: begin
                     hi_nxt   = rs_val;
                     done_nxt = 1'b1;
                  end
                  F_MTLO: begin
                     lo_nxt   = rs_val;
                     done_nxt = 1'b1;
                  end
                  F_MULT, F_MULTU: begin
                     sa_nxt     = op_signed & rs_val[WIDTH-1];
                     sb_nxt     = op_signed & rt_val[WIDTH-1];
                     is_div_nxt = 1'b0;
                     zdiv_nxt   = 1'b0;
                     cnt_nxt    = '0;
                     op_nxt     = a_mag;
`ifdef FAST_MUL_EN
                     acc_nxt    = fast_prod;
                     state_nxt  = FIX;
`else
                     acc_nxt    = {{WIDTH{1'b0}}, b_mag};
                     state_nxt  = MUL;
`endif
                  end
                  F_DIV, F_DIVU: begin
                     sa_nxt     = op_signed & rs_val[WIDTH-1];
                     sb_nxt     = op_signed & rt_val[WIDTH-1];
                     is_div_nxt = 1'b1;
                     zdiv_nxt   = (rt_val == '0);
                     cnt_nxt    = '0;
                     op_nxt     = b_mag;
                     acc_nxt    = {{WIDTH{1'b0}}, a_mag};
                     state_nxt  = DIV;
                  end
                  default: ;
               endcase
            end
         end
         MUL: begin
            if (flush) begin
               state_nxt = IDLE;
            end else begin
               acc_nxt = {mul_sum, acc[WIDTH-1:1]};
               cnt_nxt = cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
            end
         end
         DIV: begin
            if (flush) begin
               state_nxt = IDLE;
            end else begin
               if (div_ge) acc_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
               else        acc_nxt = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
               cnt_nxt = cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) state_nxt = FIX;
            end
         end
         FIX: begin
            state_nxt = IDLE;
            if (!flush) begin
               if (is_div) begin
                  hi_nxt = rem_fix;
                  lo_nxt = zdiv ? '1 : quo_fix;
               end else begin
                  hi_nxt = prod_fix[2*WIDTH-1:WIDTH];
                  lo_nxt = prod_fix[WIDTH-1:0];
               end
               done_nxt = 1'b1;
               dbz_nxt  = is_div & zdiv;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         acc         <= '0;
         op          <= '0;
         sa          <= 1'b0;
         sb          <= 1'b0;
         is_div      <= 1'b0;
         zdiv        <= 1'b0;
         hi          <= '0;
         lo          <= '0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         state       <= state_nxt;
         cnt         <= cnt_nxt;
         acc         <= acc_nxt;
         op          <= op_nxt;
         sa          <= sa_nxt;
         sb          <= sb_nxt;
         is_div      <= is_div_nxt;
         zdiv        <= zdiv_nxt;
         hi          <= hi_nxt;
         lo          <= lo_nxt;
         done        <= done_nxt;
         div_by_zero <= dbz_nxt;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_mips_muldiv_unit
//   Directed bench for mips_muldiv_unit: a WIDTH=32 instance for the main
//   vectors and a WIDTH=8 instance for the narrow-width vectors. Latency is
//   counted as the cycle index of done, where the cycle right after the
//   accept edge is cycle 1.
// -----------------------------------------------------------------------------
module tb_mips_muldiv_unit;

   localparam int W = 32;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MTLO  = 6'b010011;
   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam int DIV_LAT  = W + 2;
   localparam int DIV_LAT8 = 10;
`ifdef FAST_MUL_EN
   localparam int MUL_LAT  = 2;
   localparam int MUL_LAT8 = 2;
   localparam logic [5:0] FLUSH_OP = F_DIVU;
`else
   localparam int MUL_LAT  = W + 2;
   localparam int MUL_LAT8 = 10;
   localparam logic [5:0] FLUSH_OP = F_MULT;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic [5:0]    funct = '0;
   logic [W-1:0]  rs_val = '0;
   logic [W-1:0]  rt_val = '0;
   logic          flush = 1'b0;
   logic          busy, done, div_by_zero;
   logic [W-1:0]  hi, lo;

   logic          start8 = 1'b0;
   logic [5:0]    funct8 = '0;
   logic [7:0]    rs8 = '0;
   logic [7:0]    rt8 = '0;
   logic          flush8 = 1'b0;
   logic          busy8, done8, dbz8;
   logic [7:0]    hi8, lo8;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mips_muldiv_unit #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .funct(funct),
      .rs_val(rs_val), .rt_val(rt_val), .flush(flush),
      .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
   );

   mips_muldiv_unit #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .funct(funct8),
      .rs_val(rs8), .rt_val(rt8), .flush(flush8),
      .busy(busy8), .done(done8), .div_by_zero(dbz8), .hi(hi8), .lo(lo8)
   );

   // ---------------- driver tasks ----------------
   // Present a request for one cycle; returns 1ns after the accept edge.
   task automatic issue(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      start = 1'b1; funct = f; rs_val = a; rt_val = b;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Waits (bounded) for done; cyc = cycle index of done, 0 on timeout.
   task automatic wait_done(output int cyc, output logic dz);
      cyc = 1;
      while (done !== 1'b1 && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (done !== 1'b1) cyc = 0;
      dz = div_by_zero;
   endtask

   task automatic run(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                      output int cyc, output logic dz);
      issue(f, a, b);
      wait_done(cyc, dz);
   endtask

   task automatic run8(input logic [5:0] f, input logic [7:0] a, input logic [7:0] b,
                       output int cyc);
      @(negedge clk);
      start8 = 1'b1; funct8 = f; rs8 = a; rt8 = b;
      @(posedge clk);
      #1;
      start8 = 1'b0;
      cyc = 1;
      while (done8 !== 1'b1 && cyc < 100) begin
         @(posedge clk);
         #1;
         cyc++;
      end
      if (done8 !== 1'b1) cyc = 0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      int   cyc;
      logic dz;
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0 || div_by_zero !== 1'b0) begin
         $display("FAIL reset_state got hi=%h lo=%h busy=%b done=%b dbz=%b exp all zero",
                  hi, lo, busy, done, div_by_zero);
         errors++;
      end
      @(negedge clk); rst_n = 1'b1;

      issue(F_MTHI, 32'h12345678, 32'h0);
      checks++;
      if (busy !== 1'b0) begin
         $display("FAIL mthi_busy got %b exp 0", busy); errors++;
      end
      wait_done(cyc, dz);
      checks++;
      if (hi !== 32'h12345678) begin
         $display("FAIL mthi_hi got %h exp 12345678", hi); errors++;
      end
      checks++;
      if (cyc !== 1) begin
         $display("FAIL mthi_latency got %0d exp 1", cyc); errors++;
      end

      // Reset in the middle of a division.
      run(F_MTLO, 32'h00000055, 32'h0, cyc, dz);
      issue(F_DIV, 32'h00001000, 32'h00000003);
      repeat (3) @(posedge clk);
      @(negedge clk); rst_n = 1'b0;
      #1;
      checks++;
      if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         $display("FAIL reset_mid_div got hi=%h lo=%h busy=%b done=%b exp 0 0 0 0",
                  hi, lo, busy, done);
         errors++;
      end
      @(negedge clk); rst_n = 1'b1;
      cyc = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) cyc++;
      end
      checks++;
      if (cyc !== 0) begin
         $display("FAIL reset_abandon got %0d active cycles exp 0", cyc); errors++;
      end
   endtask

   task automatic test_mult();
      int   cyc;
      logic dz;
      run(F_MULT, 32'hFFFFFFFE, 32'h00000003, cyc, dz);
      checks++;
      if (hi !== 32'hFFFFFFFF || lo !== 32'hFFFFFFFA) begin
         $display("FAIL mult_neg got %h_%h exp ffffffff_fffffffa", hi, lo); errors++;
      end
      checks++;
      if (cyc !== MUL_LAT) begin
         $display("FAIL mult_latency got %0d exp %0d", cyc, MUL_LAT); errors++;
      end
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b0) begin
         $display("FAIL done_pulse_width got %b exp 0", done); errors++;
      end

      run(F_MULTU, 32'hFFFFFFFE, 32'h00000003, cyc, dz);
      checks++;
      if (hi !== 32'h00000002 || lo !== 32'hFFFFFFFA) begin
         $display("FAIL multu got %h_%h exp 00000002_fffffffa", hi, lo); errors++;
      end

      // MIN * MIN = 2^62
      run(F_MULT, 32'h80000000, 32'h80000000, cyc, dz);
      checks++;
      if (hi !== 32'h40000000 || lo !== 32'h00000000) begin
         $display("FAIL mult_min_min got %h_%h exp 40000000_00000000", hi, lo); errors++;
      end
   endtask

   task automatic test_div();
      int   cyc;
      logic dz;
      run(F_DIV, 32'hFFFFFFF9, 32'h00000002, cyc, dz);
      checks++;
      if (lo !== 32'hFFFFFFFD || hi !== 32'hFFFFFFFF) begin
         $display("FAIL div_neg got lo=%h hi=%h exp fffffffd ffffffff", lo, hi); errors++;
      end
      checks++;
      if (cyc !== DIV_LAT || dz !== 1'b0) begin
         $display("FAIL div_latency got %0d dbz=%b exp %0d dbz=0", cyc, dz, DIV_LAT); errors++;
      end

      run(F_DIVU, 32'h80000000, 32'hFFFFFFFF, cyc, dz);
      checks++;
      if (lo !== 32'h00000000 || hi !== 32'h80000000) begin
         $display("FAIL divu got lo=%h hi=%h exp 00000000 80000000", lo, hi); errors++;
      end

      run(F_DIV, 32'h0000002A, 32'h00000000, cyc, dz);
      checks++;
      if (hi !== 32'h0000002A || lo !== 32'hFFFFFFFF || dz !== 1'b1) begin
         $display("FAIL div_by_zero got hi=%h lo=%h dbz=%b exp 0000002a ffffffff 1", hi, lo, dz);
         errors++;
      end
      checks++;
      if (cyc !== DIV_LAT) begin
         $display("FAIL div_by_zero_latency got %0d exp %0d", cyc, DIV_LAT); errors++;
      end

      run(F_DIV, 32'hFFFFFFF3, 32'h00000000, cyc, dz);
      checks++;
      if (hi !== 32'hFFFFFFF3 || lo !== 32'hFFFFFFFF || dz !== 1'b1) begin
         $display("FAIL div_by_zero_neg got hi=%h lo=%h dbz=%b exp fffffff3 ffffffff 1", hi, lo, dz);
         errors++;
      end

      run(F_DIV, 32'h80000000, 32'hFFFFFFFF, cyc, dz);
      checks++;
      if (lo !== 32'h80000000 || hi !== 32'h00000000 || dz !== 1'b0) begin
         $display("FAIL div_overflow got lo=%h hi=%h dbz=%b exp 80000000 00000000 0", lo, hi, dz);
         errors++;
      end
   endtask

   task automatic test_busy_ignore();
      int cyc;
      int extra;
      issue(F_DIV, 32'd100, 32'd7);
      repeat (4) @(posedge clk);
      cyc = 5;
      @(negedge clk);
      start = 1'b1; funct = F_MULTU; rs_val = 32'hFFFFFFFF; rt_val = 32'hFFFFFFFF;
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      checks++;
      if (busy !== 1'b1) begin
         $display("FAIL ignore_busy got busy=%b exp 1", busy); errors++;
      end
      while (done !== 1'b1 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      checks++;
      if (lo !== 32'd14 || hi !== 32'd2 || cyc !== DIV_LAT) begin
         $display("FAIL ignore_result got lo=%h hi=%h cyc=%0d exp 0000000e 00000002 %0d",
                  lo, hi, cyc, DIV_LAT);
         errors++;
      end
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1 || busy === 1'b1) extra++;
      end
      checks++;
      if (extra !== 0 || hi !== 32'd2) begin
         $display("FAIL ignore_not_queued got %0d active cycles hi=%h exp 0 00000002", extra, hi);
         errors++;
      end
   endtask

   task automatic test_flush();
      int   cyc;
      logic dz;
      int   extra;
      run(F_MTHI, 32'h11111111, 32'h0, cyc, dz);
      run(F_MTLO, 32'h22222222, 32'h0, cyc, dz);

      issue(FLUSH_OP, 32'h12345678, 32'h00000009);
      repeat (4) @(posedge clk);
      #1;
      checks++;
      if (busy !== 1'b1) begin
         $display("FAIL flush_pre_busy got %b exp 1", busy); errors++;
      end
      @(negedge clk); flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checks++;
      if (busy !== 1'b0) begin
         $display("FAIL flush_busy_drop got %b exp 0", busy); errors++;
      end
      extra = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done === 1'b1) extra++;
      end
      checks++;
      if (extra !== 0 || hi !== 32'h11111111 || lo !== 32'h22222222) begin
         $display("FAIL flush_no_write got dones=%0d hi=%h lo=%h exp 0 11111111 22222222",
                  extra, hi, lo);
         errors++;
      end

      // flush landing in the fix-up cycle of a division
      issue(F_DIVU, 32'd50, 32'd5);
      repeat (W) @(posedge clk);
      @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin
         $display("FAIL fix_flush_busy got %b exp 1", busy); errors++;
      end
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'h11111111 || lo !== 32'h22222222) begin
         $display("FAIL fix_flush got done=%b busy=%b hi=%h lo=%h exp 0 0 11111111 22222222",
                  done, busy, hi, lo);
         errors++;
      end

      // flush together with start in IDLE: start wins
      @(negedge clk);
      flush = 1'b1; start = 1'b1; funct = F_MTHI; rs_val = 32'hCAFEF00D;
      @(posedge clk); #1;
      flush = 1'b0; start = 1'b0;
      checks++;
      if (hi !== 32'hCAFEF00D || done !== 1'b1) begin
         $display("FAIL flush_start_idle got hi=%h done=%b exp cafef00d 1", hi, done); errors++;
      end
   endtask

   task automatic test_back_to_back();
      int   cyc;
      logic dz;
      run(F_MULTU, 32'd5, 32'd7, cyc, dz);
      // next request presented during the done cycle
      issue(F_MTLO, 32'h0000ABCD, 32'h0);
      checks++;
      if (lo !== 32'h0000ABCD || hi !== 32'h00000000 || done !== 1'b1) begin
         $display("FAIL back_to_back got lo=%h hi=%h done=%b exp 0000abcd 00000000 1",
                  lo, hi, done);
         errors++;
      end
      issue(6'b100000, 32'hDEADBEEF, 32'h1);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0 || lo !== 32'h0000ABCD || hi !== 32'h0) begin
         $display("FAIL bad_funct got busy=%b done=%b lo=%h hi=%h exp 0 0 0000abcd 00000000",
                  busy, done, lo, hi);
         errors++;
      end
   endtask

   task automatic test_width8();
      int cyc;
      run8(F_MULT, 8'hFE, 8'h03, cyc);
      checks++;
      if (hi8 !== 8'hFF || lo8 !== 8'hFA || cyc !== MUL_LAT8) begin
         $display("FAIL w8_mult got %h_%h cyc=%0d exp ff_fa %0d", hi8, lo8, cyc, MUL_LAT8);
         errors++;
      end
      run8(F_MULTU, 8'hFE, 8'h03, cyc);
      checks++;
      if (hi8 !== 8'h02 || lo8 !== 8'hFA) begin
         $display("FAIL w8_multu got %h_%h exp 02_fa", hi8, lo8); errors++;
      end
      run8(F_DIV, 8'hF9, 8'h02, cyc);
      checks++;
      if (lo8 !== 8'hFD || hi8 !== 8'hFF || cyc !== DIV_LAT8) begin
         $display("FAIL w8_div got lo=%h hi=%h cyc=%0d exp fd ff %0d", lo8, hi8, cyc, DIV_LAT8);
         errors++;
      end
      run8(F_DIVU, 8'h80, 8'hFF, cyc);
      checks++;
      if (lo8 !== 8'h00 || hi8 !== 8'h80) begin
         $display("FAIL w8_divu got lo=%h hi=%h exp 00 80", lo8, hi8); errors++;
      end
   endtask

   initial begin
      test_reset();
      test_mult();
      test_div();
      test_busy_ignore();
      test_flush();
      test_back_to_back();
      test_width8();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
Parametrised iterative multiply/divide unit with HI/LO result registers, the sequential companion to the combinational MIPS ALU. It handles R-type mult, multu, div, divu, mthi and mtlo. It accepts an operation through a start/busy/done handshake and holds HI/LO until the next write. Results are read by the datapath directly from the hi/lo outputs (mfhi/mflo path).

Parameters:
WIDTH, 32, operand and HI/LO width in bits; must be at least 4.
CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, do not override.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only when busy=0
funct  in  6  instruction funct field: 011000 mult, 011001 multu, 011010 div, 011011 divu, 010001 mthi, 010011 mtlo
rs_val  in  WIDTH  operand A (multiplicand / dividend / mthi-mtlo source)
rt_val  in  WIDTH  operand B (multiplier / divisor)
flush  in  1  abort an in-flight operation
busy  out  1  operation in progress
done  out  1  one-cycle pulse: hi/lo just updated
div_by_zero  out  1  one-cycle pulse with done when the divisor was 0
hi  out  WIDTH  HI register
lo  out  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done and div_by_zero = 0; hi and lo = 0; counter and internal accumulators = 0. Reset mid-operation abandons the operation.
- States: IDLE, MUL, DIV, FIX.
- Accept: in IDLE, start=1 with a valid funct is accepted at edge E0. Start with an unsupported funct is ignored. Start while busy=1 is ignored; it is not queued.
- mthi/mtlo: at E0, hi (or lo) <= rs_val. done=1 during the following cycle. busy never asserts. div_by_zero=0.
- mult/div at E0:
  - Latch operands. For signed ops, latch magnitudes |rs_val| and |rt_val| (WIDTH-bit unsigned; |MIN| = 2^(WIDTH-1) fits) plus the sign bits.
  - busy <= 1, counter <= 0, state <= MUL or DIV.
- MUL: shift-add, one multiplier bit per cycle, 2*WIDTH-bit product accumulator. Runs for WIDTH cycles (edges E1..E_WIDTH), then goes to FIX.
- DIV: restoring division, one quotient bit per cycle, WIDTH cycles, then FIX.
- FIX (edge E_WIDTH+1):
  - Apply sign correction.
    - mult: negate the 2*WIDTH-bit product if signs differ.
    - div: quotient negated if sa^sb; remainder takes the sign of the dividend.
  - Write hi/lo. mult: hi = product[2W-1:W], lo = product[W-1:0]. div: lo = quotient, hi = remainder.
  - done <= 1, busy <= 0, state <= IDLE.
- Latency: done is high in the cycle after edge E_WIDTH+1, i.e. WIDTH+2 cycles after accept. A new start may be sampled in that same done cycle.
- Divide by zero (rt_val=0, div or divu): the full WIDTH+2 latency is kept. Result is hi = rs_val (original, not magnitude), lo = all ones, and div_by_zero pulses with done.
- Signed overflow (div, MIN / -1): lo = MIN, hi = 0. No flag.
- hi/lo change only at FIX or an mthi/mtlo accept.
- flush=1 while busy: at the next edge, state <= IDLE and busy <= 0. No done pulse; hi/lo unchanged. flush in IDLE has no effect. flush and start in the same IDLE cycle: start wins.
- flush in the FIX cycle: flush wins, and no write occurs.

Optional Feature:
FAST_MUL_EN:
- Defined: mult/multu skip MUL. The product is computed combinationally at E0 and registered, the state goes straight to FIX, and done is high 2 cycles after accept. Division is unchanged.
- Undefined: iterative multiply with WIDTH+2 latency as above.

Test Plan:
- Reset: rst_n low mid-DIV -> hi=lo=0, busy=done=0 immediately. After release, mthi rs_val=0x12345678 -> hi=0x12345678, done 1 cycle later, busy never high.
- mult rs=0xFFFFFFFE, rt=0x00000003 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA, done exactly 34 cycles after accept (WIDTH=32). multu same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- div rs=0xFFFFFFF9 (-7), rt=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu rs=0x80000000, rt=0xFFFFFFFF -> lo=0x00000000, hi=0x80000000.
- div rs=0x0000002A, rt=0 -> hi=0x0000002A, lo=0xFFFFFFFF, div_by_zero=1 with done. div rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0, div_by_zero=0.
- Start pulsed with multu while busy on a div -> ignored; only the div result is written. flush 5 cycles into a mult -> busy drops next cycle, no done, hi/lo keep prior values.
- Rerun the mult vectors with FAST_MUL_EN defined -> same results, done 2 cycles after accept. Repeat the signed/unsigned vectors with WIDTH=8: mult 0xFE×0x03 -> hi=0xFF, lo=0xFA, done 10 cycles after accept.
